// File: rtl/sspwm_pkg.sv
// Shared defaults and state encoding for the SPWM sine sequencer.
package sspwm_pkg;

    localparam int unsigned SSPWM_LUT_LEN = 20;
    localparam int unsigned SSPWM_IDX_W   = 8;
    localparam int unsigned SSPWM_AMP_W   = 12;
    localparam int unsigned SSPWM_CAR_TOP = 3711;
    localparam int unsigned SSPWM_DT_W    = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } seq_state_e;

endpackage

// File: rtl/sspwm_deadtime.sv
// Per-leg dead-time inserter: any change of the requested H/L pair blanks
// both gates, then the new pair is released once the dead-time count expires.
module sspwm_deadtime #(
    parameter int unsigned DT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_h,
    input  logic            req_l,
    input  logic [DT_W-1:0] dead_time,
    output logic            gate_h,
    output logic            gate_l
);

    logic [1:0]      req;
    logic [1:0]      req_q;
    logic [DT_W-1:0] dt_cnt;

    assign req = {req_h, req_l};

    // Track the request, blank on change, release the gate when the count runs out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= '0;
            dt_cnt <= '0;
            gate_h <= 1'b0;
            gate_l <= 1'b0;
        end else if (req != req_q) begin
            req_q  <= req;
            dt_cnt <= dead_time;
            if (dead_time == '0) begin
                {gate_h, gate_l} <= req;
            end else begin
                {gate_h, gate_l} <= '0;
            end
        end else if (dt_cnt > DT_W'(1)) begin
            dt_cnt <= dt_cnt - 1'b1;
        end else begin
            dt_cnt           <= '0;
            {gate_h, gate_l} <= req_q;
        end
    end

endmodule

// File: rtl/sspwm_sine_sequencer.sv
// Unipolar SPWM sequencer: triangular carrier, LUT index stepping,
// regular-sampled compare, leg steering and per-leg dead time.
module sspwm_sine_sequencer
    import sspwm_pkg::*;
#(
    parameter int unsigned LUT_LEN = SSPWM_LUT_LEN,
    parameter int unsigned IDX_W   = SSPWM_IDX_W,
    parameter int unsigned AMP_W   = SSPWM_AMP_W,
    parameter int unsigned CAR_TOP = SSPWM_CAR_TOP,
    parameter int unsigned DT_W    = SSPWM_DT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DT_W-1:0]  dead_time,
    input  logic [AMP_W-1:0] sine_in,
    output logic [IDX_W-1:0] teth_ta,
    output logic             gate_ah,
    output logic             gate_al,
    output logic             gate_bh,
    output logic             gate_bl,
    output logic             half_neg,
    output logic             busy,
    output logic             cycle_done
);

    localparam logic [AMP_W-1:0] TOP_V    = AMP_W'(CAR_TOP);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LUT_LEN - 1);

    seq_state_e       state, state_nxt;
    logic [AMP_W-1:0] car_cnt;
    logic             dir_down;
    logic [IDX_W-1:0] idx;
    logic [AMP_W-1:0] ref_q;
    logic             leg_b_sel;
    logic             active;
    logic             start;
    logic             at_peak;
    logic             at_valley_next;
    logic             step_idx;
    logic             raw;
    logic             req_ah, req_al, req_bh, req_bl;
    logic             dt_ah, dt_al, dt_bh, dt_bl;

    assign active         = (state != IDLE);
    assign start          = (state == IDLE) && en;
    assign at_peak        = !dir_down && (car_cnt == TOP_V);
    assign at_valley_next = dir_down && (car_cnt == AMP_W'(1));
    // With CAR_TOP==2 the value 2 is the peak itself, so the peak also counts.
    assign step_idx       = (car_cnt == AMP_W'(2)) && (dir_down || at_peak);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: DRAIN ignores en and leaves only at the carrier valley.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en)             state_nxt = RUN;
            RUN:     if (!en)            state_nxt = DRAIN;
            DRAIN:   if (at_valley_next) state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // Triangular carrier: 0..CAR_TOP up, CAR_TOP-1..1 down, parked at 0 in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car_cnt  <= '0;
            dir_down <= 1'b0;
        end else if (!active) begin
            car_cnt  <= '0;
            dir_down <= 1'b0;
        end else if (at_peak) begin
            car_cnt  <= TOP_V - 1'b1;
            dir_down <= 1'b1;
        end else if (at_valley_next) begin
            car_cnt  <= '0;
            dir_down <= 1'b0;
        end else if (dir_down) begin
            car_cnt  <= car_cnt - 1'b1;
        end else begin
            car_cnt  <= car_cnt + 1'b1;
        end
    end

    // LUT index, half-cycle polarity and full-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            half_neg   <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            if (start) begin
                idx      <= '0;
                half_neg <= 1'b0;
            end else if (active && step_idx) begin
                if (idx == IDX_LAST) begin
                    idx        <= '0;
                    half_neg   <= ~half_neg;
                    cycle_done <= half_neg;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    // Regular sample of the LUT one cycle after the index step. The leg
    // selection is latched here too, so the swap lands on the period whose
    // reference is LUT[0] rather than two cycles early on the old reference.
    // ref_q is cleared at start because a sine LUT begins at zero and the
    // held index may not be 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q     <= '0;
            leg_b_sel <= 1'b0;
        end else if (start) begin
            ref_q     <= '0;
            leg_b_sel <= 1'b0;
        end else if (active && at_valley_next) begin
            ref_q     <= sine_in;
            leg_b_sel <= half_neg;
        end
    end

    // Reference/carrier compare with clamp at the carrier peak.
    always_comb begin
        raw = 1'b0;
        if (ref_q >= TOP_V) begin
            raw = 1'b1;
        end else begin
            raw = (ref_q > car_cnt);
        end
    end

    // Leg steering: one leg modulates, the other holds its low side on.
    always_comb begin
        req_ah = 1'b0;
        req_al = 1'b0;
        req_bh = 1'b0;
        req_bl = 1'b0;
        if (active) begin
            if (leg_b_sel) begin
                req_al = 1'b1;
                req_bh = raw;
                req_bl = ~raw;
            end else begin
                req_ah = raw;
                req_al = ~raw;
                req_bl = 1'b1;
            end
        end
    end

    sspwm_deadtime #(
        .DT_W (DT_W)
    ) u_dt_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_h     (req_ah),
        .req_l     (req_al),
        .dead_time (dead_time),
        .gate_h    (dt_ah),
        .gate_l    (dt_al)
    );

    sspwm_deadtime #(
        .DT_W (DT_W)
    ) u_dt_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_h     (req_bh),
        .req_l     (req_bl),
        .dead_time (dead_time),
        .gate_h    (dt_bh),
        .gate_l    (dt_bl)
    );

    assign gate_ah = dt_ah & active;
    assign gate_al = dt_al & active;
    assign gate_bh = dt_bh & active;
    assign gate_bl = dt_bl & active;
    assign busy    = active;
    assign teth_ta = idx;

endmodule

// File: tb/tb_sspwm_sine_sequencer.sv
// Randomized bench for sspwm_sine_sequencer against a period/phase-arithmetic
// reference model, using a reduced carrier so a full sine fits a short run.
module tb_sspwm_sine_sequencer;

    localparam int unsigned TOP = 100;
    localparam int unsigned P   = 2 * TOP;
    localparam int unsigned LEN = 20;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [5:0]  dead_time;
    logic [11:0] sine_in;
    logic [7:0]  teth_ta;
    logic        gate_ah, gate_al, gate_bh, gate_bl;
    logic        half_neg, busy, cycle_done;

    logic [11:0] lut [0:LEN-1];

    int n_tests = 0;
    int n_fail  = 0;

    sspwm_sine_sequencer #(
        .LUT_LEN (LEN),
        .IDX_W   (8),
        .AMP_W   (12),
        .CAR_TOP (TOP),
        .DT_W    (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .dead_time  (dead_time),
        .sine_in    (sine_in),
        .teth_ta    (teth_ta),
        .gate_ah    (gate_ah),
        .gate_al    (gate_al),
        .gate_bh    (gate_bh),
        .gate_bl    (gate_bl),
        .half_neg   (half_neg),
        .busy       (busy),
        .cycle_done (cycle_done)
    );

    assign sine_in = (teth_ta < 8'(LEN)) ? lut[teth_ta] : 12'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    int          m_mode;      // 0 idle, 1 run, 2 drain
    int          m_n;         // cycles since run start
    int          m_cyc;
    logic [7:0]  m_idx_hold;
    logic        m_neg_hold;
    logic [1:0]  m_prev [2];
    logic [1:0]  m_g    [2];
    int          m_chg  [2];
    int          m_chgdt[2];

    int cnt_ah[64];
    int cnt_bh[64];
    int done_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode     = 0;
        m_n        = 0;
        m_idx_hold = '0;
        m_neg_hold = 1'b0;
        for (int l = 0; l < 2; l++) begin
            m_prev[l]  = 2'b00;
            m_g[l]     = 2'b00;
            m_chg[l]   = -100000;
            m_chgdt[l] = 0;
        end
    endtask

    task automatic clear_meas();
        for (int i = 0; i < 64; i++) begin
            cnt_ah[i] = 0;
            cnt_bh[i] = 0;
        end
        done_cnt = 0;
    endtask

    task automatic load_sine();
        lut[0]  = 12'd0;   lut[1]  = 12'd15;  lut[2]  = 12'd30;  lut[3]  = 12'd45;
        lut[4]  = 12'd58;  lut[5]  = 12'd70;  lut[6]  = 12'd80;  lut[7]  = 12'd89;
        lut[8]  = 12'd95;  lut[9]  = 12'd98;  lut[10] = 12'd100; lut[11] = 12'd98;
        lut[12] = 12'd95;  lut[13] = 12'd89;  lut[14] = 12'd80;  lut[15] = 12'd70;
        lut[16] = 12'd58;  lut[17] = 12'd45;  lut[18] = 12'd30;  lut[19] = 12'd15;
    endtask

    // Expected {teth_ta, ah, al, bh, bl, half_neg, busy, cycle_done} this cycle.
    function automatic logic [14:0] exp_outs();
        logic [7:0] idx;
        logic       neg;
        logic       done;
        if (m_mode == 0) return {m_idx_hold, 4'b0000, m_neg_hold, 1'b0, 1'b0};
        idx  = 8'(((m_n + 1) / P) % LEN);
        neg  = ((((m_n + 1) / P) / LEN) % 2) == 1;
        done = (((m_n + 1) % (P * LEN)) == 0) && ((((m_n + 1) / (P * LEN)) % 2) == 0);
        return {idx, m_g[0], m_g[1], neg, 1'b1, done};
    endfunction

    // Requested {H,L} for a leg from the period number and carrier phase.
    function automatic logic [1:0] leg_req(input int leg);
        int   k, t, car, rv, steer;
        logic raw;
        if (m_mode == 0) return 2'b00;
        k     = m_n / P;
        t     = m_n % P;
        car   = (t <= TOP) ? t : (P - t);
        rv    = int'(lut[k % LEN]);
        raw   = (rv >= TOP) || (rv > car);
        steer = (k / LEN) % 2;
        return (steer == leg) ? {raw, ~raw} : 2'b01;
    endfunction

    // One clock: check this cycle, drive inputs, advance the model.
    task automatic step(input logic en_v, input logic [5:0] dt_v);
        logic [14:0] obs;
        logic [1:0]  rq;
        int          w;
        obs = {teth_ta, gate_ah, gate_al, gate_bh, gate_bl, half_neg, busy, cycle_done};
        check_eq("outs", obs, exp_outs());
        check_eq("shoot_through", (gate_ah & gate_al) | (gate_bh & gate_bl), 0);
        if (m_mode != 0) begin
            done_cnt += cycle_done;
            if (m_n >= 1) begin
                w = (m_n - 1) / P;
                if (w < 64) begin
                    cnt_ah[w] += gate_ah;
                    cnt_bh[w] += gate_bh;
                end
            end
        end
        en        = en_v;
        dead_time = dt_v;
        for (int l = 0; l < 2; l++) begin
            rq = leg_req(l);
            if (rq != m_prev[l]) begin
                m_prev[l]  = rq;
                m_chg[l]   = m_cyc;
                m_chgdt[l] = int'(dt_v);
            end
            m_g[l] = (m_cyc >= m_chg[l] + m_chgdt[l]) ? rq : 2'b00;
        end
        case (m_mode)
            0: if (en_v) begin
                m_mode = 1;
                m_n    = 0;
            end
            1: begin
                if (!en_v) m_mode = 2;
                m_n++;
            end
            default: begin
                if ((m_n % P) == P - 1) begin
                    m_mode     = 0;
                    m_idx_hold = 8'(((m_n + 1) / P) % LEN);
                    m_neg_hold = ((((m_n + 1) / P) / LEN) % 2) == 1;
                end
                m_n++;
            end
        endcase
        m_cyc++;
        @(negedge clk);
    endtask

    task automatic run_cycles(input int ncyc, input logic en_v, input logic [5:0] dt_v);
        for (int i = 0; i < ncyc; i++) step(en_v, dt_v);
    endtask

    task automatic drain_to_idle(input logic toggle, input logic [5:0] dt_v);
        step(1'b0, dt_v);
        for (int i = 0; i < int'(P) + 4 && m_mode != 0; i++)
            step(toggle ? 1'($urandom_range(0, 1)) : 1'b0, dt_v);
        check_eq("drain_idle", busy, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] dt;
        int         len;
        rst_n     = 1'b0;
        en        = 1'b0;
        dead_time = '0;
        m_cyc     = 0;
        load_sine();
        model_reset();
        clear_meas();

        @(negedge clk);
        check_eq("reset", {teth_ta, gate_ah, gate_al, gate_bh, gate_bl, half_neg, busy, cycle_done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(3, 1'b0, 6'd0);

        // dead_time=0: period 0 idle-high low sides, period 1 ref=15 -> 29 clks high
        clear_meas();
        run_cycles(2 * P + 2, 1'b1, 6'd0);
        check_eq("ah_p0_dt0", cnt_ah[0], 0);
        check_eq("ah_p1_dt0", cnt_ah[1], 2 * int'(lut[1]) - 1);

        // run into the negative half, then drop en mid-period
        run_cycles(20 * P + $urandom_range(0, P - 1), 1'b1, 6'd0);
        drain_to_idle(1'b0, 6'd0);
        run_cycles(5, 1'b0, 6'd0);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_half_hold", half_neg, 1);

        // restart with dead_time=4 and run a full sine plus one period
        clear_meas();
        run_cycles(3, 1'b1, 6'd4);
        check_eq("restart_idx", teth_ta, 0);
        check_eq("restart_half", half_neg, 0);
        run_cycles(41 * P, 1'b1, 6'd4);
        // period 1 window holds two rising edges (its own start and the one
        // before the next valley), each shortened by the dead time
        check_eq("ah_p1_dt4", cnt_ah[1], 2 * int'(lut[1]) - 1 - 2 * 4);
        check_eq("ah_p10_clamp", cnt_ah[10], 2 * TOP);
        check_eq("bh_p21_dt4", cnt_bh[21], 2 * int'(lut[1]) - 1 - 2 * 4);
        check_eq("ah_p21_clamped", cnt_ah[21], 0);
        check_eq("cycle_done_count", done_cnt, 1);
        drain_to_idle(1'b1, 6'd4);

        // random LUT contents, dead times and run lengths
        repeat (4) begin
            for (int i = 1; i < int'(LEN); i++) lut[i] = 12'($urandom_range(0, TOP + 3));
            dt  = 6'($urandom_range(0, 9));
            len = $urandom_range(P / 2, 3 * P);
            clear_meas();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 31) == 0) dt = 6'($urandom_range(0, 9));
                step(1'b1, dt);
            end
            drain_to_idle(1'b1, dt);
            run_cycles($urandom_range(1, 5), 1'b0, dt);
        end

        // asynchronous reset while gate_ah is high
        load_sine();
        for (int i = 0; i < 3 * int'(P) && gate_ah !== 1'b1; i++) step(1'b1, 6'd0);
        check_eq("ah_high_before_rst", gate_ah, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst", {teth_ta, gate_ah, gate_al, gate_bh, gate_bl, half_neg, busy, cycle_done}, 0);
        model_reset();
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(3, 1'b0, 6'd0);
        run_cycles(P + 5, 1'b1, 6'd2);
        drain_to_idle(1'b0, 6'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
